// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM encoding,
// fault rule and store lane helpers.
package load_store_unit_pkg;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   function automatic logic is_fault(input logic we, input logic [2:0] funct3,
                                     input logic [1:0] off);
      logic f;
      case (funct3)
         F3_B:         f = 1'b0;
         F3_H:         f = off[0];
         F3_W:         f = (off != 2'b00);
         F3_BU:        f = we;
         F3_HU:        f = we | off[0];
         default:      f = 1'b1;
      endcase
      return f;
   endfunction

   function automatic logic [3:0] store_mask(input logic [2:0] funct3, input logic [1:0] off);
      logic [3:0] m;
      case (funct3)
         F3_B:    m = 4'b0001 << off;
         F3_H:    m = 4'b0011 << off;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
      logic [31:0] d;
      case (funct3)
         F3_B:    d = {4{wdata[7:0]}};
         F3_H:    d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data extraction: picks the addressed byte/halfword and sign/zero-extends.
// Purely combinational, no backpressure.
module load_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (funct3)
         F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   data = {24'd0, byte_sel};
         F3_H:    data = {{16{half_sel[15]}}, half_sel};
         F3_HU:   data = {16'd0, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit between the AGU and a word-wide data memory.
// Latency: response 2 cycles after accept plus memory wait cycles; faults respond after 1.
// Backpressure: req_ready only in IDLE; ACCESS holds the memory request until dmem_ready.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wdata,
   input  logic [4:0]            req_rd,
   output logic                  dmem_en,
   output logic [3:0]            dmem_we,
   output logic [ADDR_WIDTH-1:0] dmem_addr,
   output logic [31:0]           dmem_wdata,
   input  logic [31:0]           dmem_rdata,
   input  logic                  dmem_ready,
   output logic                  resp_valid,
   output logic [31:0]           resp_rdata,
   output logic [4:0]            resp_rd,
   output logic                  resp_fault
);

   state_t      state;
   logic        we_q;
   logic [2:0]  funct3_q;
   logic [1:0]  addr_lo_q;
   logic [4:0]  rd_q;
   logic [31:0] load_data;
   logic        req_fault;

   assign req_ready = (state == ST_IDLE);
   assign resp_rd   = rd_q;
   assign req_fault = is_fault(req_we, req_funct3, req_addr[1:0]);

   // Alignment works on the live memory word so the extracted value lands
   // directly in the resp_rdata flop on the capture edge.
   load_align u_load_align (
      .rdata   (dmem_rdata),
      .addr_lo (addr_lo_q),
      .funct3  (funct3_q),
      .data    (load_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         we_q       <= 1'b0;
         funct3_q   <= 3'd0;
         addr_lo_q  <= 2'd0;
         rd_q       <= 5'd0;
         dmem_en    <= 1'b0;
         dmem_we    <= 4'd0;
         dmem_addr  <= '0;
         dmem_wdata <= 32'd0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_fault <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q       <= req_we;
                  funct3_q   <= req_funct3;
                  addr_lo_q  <= req_addr[1:0];
                  rd_q       <= req_rd;
                  dmem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                  dmem_wdata <= store_data(req_funct3, req_wdata);
                  if (req_fault) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_fault <= 1'b1;
                     resp_rdata <= 32'd0;
                  end else begin
                     state   <= ST_ACCESS;
                     dmem_en <= 1'b1;
                     dmem_we <= req_we ? store_mask(req_funct3, req_addr[1:0]) : 4'd0;
                  end
               end
            end
            ST_ACCESS: begin
               if (dmem_ready) begin
                  state      <= ST_RESP;
                  dmem_en    <= 1'b0;
                  dmem_we    <= 4'd0;
                  resp_valid <= 1'b1;
                  resp_rdata <= we_q ? 32'd0 : load_data;
               end
            end
            ST_RESP: begin
               state      <= ST_IDLE;
               resp_valid <= 1'b0;
               resp_fault <= 1'b0;
               resp_rdata <= 32'd0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a per-cycle reference model compare.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr, req_wdata;
   logic [4:0]  req_rd;
   logic        dmem_en;
   logic [3:0]  dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic        dmem_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic [4:0]  resp_rd;
   logic        resp_fault;

   load_store_unit #(.ADDR_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .dmem_en(dmem_en), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd), .resp_fault(resp_fault)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Expected behaviour of the current cycle: 0 idle, 1 memory access, 2 response.
   int          exp_phase = 0;
   logic        check_on = 1'b0;
   logic        exp_is_store;
   logic [3:0]  exp_mask;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;
   logic        exp_fault;
   logic [4:0]  exp_rd;
   int          exp_lat, acc_cyc;
   logic [3:0]  last_we;
   logic [31:0] last_addr, last_wdata, last_rdata;
   logic        last_fault;
   int          last_lat;

   function automatic logic mdl_fault(input logic we, input int f3, input logic [31:0] a);
      return (f3 == 3) || (f3 > 5) || ((f3 == 1 || f3 == 5) && (a % 2 != 0)) ||
             (f3 == 2 && (a % 4 != 0)) || (we && f3 >= 4);
   endfunction

   function automatic logic [3:0] mdl_mask(input logic we, input int f3, input logic [31:0] a);
      int off = int'(a % 4);
      if (!we) return 4'd0;
      if (f3 == 0) return 4'(1 << off);
      if (f3 == 1) return 4'(3 << off);
      return 4'hF;
   endfunction

   function automatic logic [31:0] mdl_wdata(input int f3, input logic [31:0] d);
      if (f3 == 0) return (d & 32'hFF) * 32'h01010101;
      if (f3 == 1) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [31:0] mdl_load(input int f3, input logic [31:0] a, input logic [31:0] w);
      logic [31:0] sh = w >> (8 * (a % 4));
      logic [31:0] v;
      case (f3)
         0: begin v = sh & 32'hFF;   if (v >= 128)   v = v + 32'hFFFFFF00; end
         4: v = sh & 32'hFF;
         1: begin v = sh & 32'hFFFF; if (v >= 32768) v = v + 32'hFFFF0000; end
         5: v = sh & 32'hFFFF;
         default: v = w;
      endcase
      return v;
   endfunction

   always @(negedge clk) begin
      if (check_on) begin
         chk("req_ready", req_ready, exp_phase == 0);
         chk("dmem_en", dmem_en, exp_phase == 1);
         chk("dmem_we", dmem_we, (exp_phase == 1) ? exp_mask : 4'd0);
         chk("resp_valid", resp_valid, exp_phase == 2);
         chk("resp_fault", resp_fault, exp_phase == 2 && exp_fault);
         if (exp_phase == 1) begin
            chk("dmem_addr", dmem_addr, exp_addr);
            if (exp_is_store) chk("dmem_wdata", dmem_wdata, exp_wdata);
            last_we    = dmem_we;
            last_addr  = dmem_addr;
            last_wdata = dmem_wdata;
         end
         if (exp_phase == 2) begin
            chk("resp_rdata", resp_rdata, exp_rdata);
            chk("resp_rd", resp_rd, exp_rd);
            chk("latency", cyc - acc_cyc + 1, exp_lat);
            last_rdata = resp_rdata;
            last_fault = resp_fault;
            last_lat   = cyc - acc_cyc + 1;
         end
      end
   end

   task automatic run_req(input logic we, input int f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [4:0] rd,
                          input logic [31:0] rdw, input int waits);
      exp_is_store = we;
      exp_fault    = mdl_fault(we, f3, a);
      exp_mask     = mdl_mask(we, f3, a);
      exp_addr     = a - (a % 4);
      exp_wdata    = mdl_wdata(f3, wd);
      exp_rdata    = (exp_fault || we) ? 32'd0 : mdl_load(f3, a, rdw);
      exp_rd       = rd;
      req_we = we; req_funct3 = 3'(f3); req_addr = a; req_wdata = wd; req_rd = rd;
      req_valid = 1'b1;
      acc_cyc = cyc + 1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_addr  = 32'hFFFF_FFFF;
      req_wdata = 32'h5A5A_5A5A;
      if (exp_fault) begin
         exp_lat = 1;
         exp_phase = 2;
      end else begin
         exp_phase = 1;
         for (int i = 0; i < waits; i++) begin
            dmem_ready = 1'b0;
            dmem_rdata = ~rdw;
            @(posedge clk); #1;
         end
         dmem_ready = 1'b1;
         dmem_rdata = rdw;
         @(posedge clk); #1;
         dmem_ready = 1'b0;
         dmem_rdata = ~rdw;
         exp_lat = 2 + waits;
         exp_phase = 2;
      end
      @(posedge clk); #1;
      exp_phase = 0;
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
      req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
      dmem_rdata = 32'd0; dmem_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_on = 1'b1;
      chk("rst_dmem_addr", dmem_addr, 32'd0);
      chk("rst_dmem_wdata", dmem_wdata, 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_rd", resp_rd, 5'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      run_req(1'b1, 2, 32'h100, 32'hDEADBEEF, 5'd1, 32'd0, 0);
      chk("sw_mask", last_we, 4'b1111);
      chk("sw_addr", last_addr, 32'h100);
      chk("sw_lat", last_lat, 2);
      chk("sw_fault", last_fault, 1'b0);

      run_req(1'b1, 1, 32'h102, 32'h1234, 5'd2, 32'd0, 0);
      chk("sh_mask", last_we, 4'b1100);
      chk("sh_wdata", last_wdata, 32'h12341234);

      run_req(1'b1, 0, 32'h101, 32'h000000AB, 5'd3, 32'd0, 1);
      chk("sb_mask", last_we, 4'b0010);
      chk("sb_wdata", last_wdata, 32'hABABABAB);

      run_req(1'b0, 0, 32'h103, 32'hx, 5'd5, 32'h80FF0000, 0);
      chk("lb_data", last_rdata, 32'hFFFFFF80);
      run_req(1'b0, 4, 32'h103, 32'hx, 5'd6, 32'h80FF0000, 0);
      chk("lbu_data", last_rdata, 32'h00000080);
      run_req(1'b0, 1, 32'h102, 32'hx, 5'd7, 32'h80FF0000, 0);
      chk("lh_data", last_rdata, 32'hFFFF80FF);
      run_req(1'b0, 5, 32'h100, 32'hx, 5'd8, 32'h80FF8001, 2);
      chk("lhu_data", last_rdata, 32'h00008001);
      run_req(1'b0, 0, 32'h100, 32'hx, 5'd9, 32'hFFFFFF7F, 0);
      chk("lb_pos", last_rdata, 32'h0000007F);

      run_req(1'b0, 2, 32'h101, 32'hx, 5'd10, 32'h11111111, 0);
      chk("lw_mis_fault", last_fault, 1'b1);
      chk("lw_mis_rdata", last_rdata, 32'd0);
      chk("lw_mis_lat", last_lat, 1);

      run_req(1'b0, 2, 32'h104, 32'hx, 5'd11, 32'hCAFEF00D, 3);
      chk("lw_wait_data", last_rdata, 32'hCAFEF00D);
      chk("lw_wait_lat", last_lat, 5);

      run_req(1'b1, 4, 32'h108, 32'h1, 5'd12, 32'd0, 0);
      run_req(1'b0, 3, 32'h108, 32'hx, 5'd13, 32'd0, 0);
      run_req(1'b0, 7, 32'h108, 32'hx, 5'd14, 32'd0, 0);
      run_req(1'b1, 1, 32'h103, 32'h2, 5'd15, 32'd0, 0);
      run_req(1'b0, 1, 32'h101, 32'hx, 5'd16, 32'd0, 0);
      run_req(1'b1, 2, 32'h10C, 32'h0BADF00D, 5'd17, 32'd0, 0);

      // Reset arriving while the memory access is still pending.
      exp_is_store = 1'b0; exp_mask = 4'd0; exp_addr = 32'h200;
      req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h200; req_rd = 5'd20;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      exp_phase = 1;
      dmem_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_phase = 0;
      chk("rstacc_addr", dmem_addr, 32'd0);
      chk("rstacc_rd", resp_rd, 5'd0);
      dmem_ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      dmem_ready = 1'b0;

      run_req(1'b0, 2, 32'h300, 32'hx, 5'd21, 32'h13572468, 0);
      chk("post_rst_lw", last_rdata, 32'h13572468);

      check_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, byte-address width of req_addr and dmem_addr.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req_valid input 1 and req_ready output 1: request handshake; transfer occurs when both are high on a rising edge.
REQ-005 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-006 SHALL have port req_funct3  input  3  RV32I width code: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU.
REQ-007 SHALL have port req_addr  input  ADDR_WIDTH  effective byte address, base plus sign-extended 12-bit offset, from the upstream address adder.
REQ-008 SHALL have ports req_wdata input 32 (store data, low-aligned) and req_rd input 5 (load destination register tag).
REQ-009 SHALL have ports dmem_en output 1, dmem_we output 4 (byte write mask), dmem_addr output ADDR_WIDTH (word-aligned), dmem_wdata output 32.
REQ-010 SHALL have ports dmem_rdata input 32 and dmem_ready input 1 (access complete; rdata valid in the same cycle).
REQ-011 SHALL have ports resp_valid output 1, resp_rdata output 32, resp_rd output 5, resp_fault output 1.

Function
REQ-012 SHALL implement three states: IDLE, ACCESS, RESP.
REQ-013 SHALL drive req_ready high only in IDLE.
REQ-014 On an accepted request, SHALL register we, funct3, addr, wdata and rd, then enter ACCESS, or enter RESP directly if the request faults.
REQ-015 Fault conditions: funct3 in {3,6,7}; halfword with addr[0]=1; word with addr[1:0]!=0; store with funct3 in {4,5}.
REQ-016 A faulting request SHALL never assert dmem_en; resp_fault=1 and resp_rdata=0 in its RESP cycle.
REQ-017 In ACCESS, SHALL hold dmem_en=1 with constant dmem_addr/dmem_we/dmem_wdata until dmem_ready is sampled high, then enter RESP.
REQ-018 SHALL drive dmem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
REQ-019 Stores: SB mask 4'b0001<<addr[1:0], data replicated ×4; SH mask 4'b0011<<addr[1:0], data replicated ×2; SW mask 4'b1111. Loads: dmem_we=0.
REQ-020 SHALL capture dmem_rdata in the cycle dmem_ready is high; in RESP, extract the addressed byte/halfword, sign-extend for LB/LH, zero-extend for LBU/LHU, pass through for LW.
REQ-021 RESP SHALL last exactly one cycle: resp_valid=1, resp_rd = registered rd, then return to IDLE; stores report resp_rdata=0.
REQ-022 Latency: accept at edge N, dmem_ready high in cycle N+1 → resp_valid in cycle N+2; each extra wait cycle adds one; faults → resp_valid in cycle N+1.
REQ-023 Outside ACCESS, dmem_en=0 and dmem_we=0; outside RESP, resp_valid=0 and resp_fault=0.
REQ-024 No request accepted while ACCESS or RESP is active; upstream SHALL hold req_* stable while req_valid=1 and req_ready=0.

Reset
REQ-025 With rst high at an edge, SHALL enter IDLE; registered fields cleared to 0.
REQ-026 Reset values: req_ready=1, dmem_en=0, dmem_we=0, dmem_addr=0, dmem_wdata=0, resp_valid=0, resp_rdata=0, resp_rd=0, resp_fault=0.
REQ-027 Reset mid-ACCESS SHALL deassert dmem_en/dmem_we on the next cycle and discard the pending response.

Structure
REQ-028 Shared package SHALL hold funct3 width-code constants and state encoding (IDLE=0, ACCESS=1, RESP=2).
REQ-029 Load extraction/extension SHALL be a combinational sub-module load_align (inputs rdata, addr[1:0], funct3; output 32-bit data).

Verification
REQ-030 SW addr 0x100, wdata 0xDEADBEEF, dmem_ready high immediately → dmem_we=4'b1111, dmem_addr=0x100, resp_valid at N+2, resp_fault=0.
REQ-031 LB addr 0x103, rdata 0x80FF0000 → resp_rdata 0xFFFFFF80; LBU same → 0x00000080; LH addr 0x102 → 0xFFFF80FF.
REQ-032 SH addr 0x102, wdata 0x1234 → dmem_we=4'b1100, dmem_wdata=0x12341234.
REQ-033 LW addr 0x101 → no dmem_en, resp_valid at N+1 with resp_fault=1, resp_rdata=0.
REQ-034 LW with dmem_ready low for 3 cycles → dmem_en held 4 cycles with stable outputs, req_ready=0 throughout, resp_valid at N+5.
REQ-035 rst asserted during ACCESS → dmem_en=0 next cycle, no resp_valid, req_ready=1.
